// File: rtl/apb_cmd_master_pkg.sv
// Shared definitions for the APB command master: bus data width, FSM state
// encodings and the UART bridge register map.
package apb_cmd_master_pkg;

    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ERROR  = 3'd3,
        ST_RESP   = 3'd4
    } apb_state_e;

    localparam logic [3:0] REG_DATA    = 4'h0;
    localparam logic [3:0] REG_STATE   = 4'h4;
    localparam logic [3:0] REG_CNTRL   = 4'h8;
    localparam logic [3:0] REG_BAUDDIV = 4'hC;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait-state counter; expired flags the last permitted
// wait cycle (count == TIMEOUT-1).
module apb_wait_timer #(
    parameter int TIMEOUT = 256
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_r;

    // Count wait cycles; clear has priority and the count never wraps past LAST.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (enable && (count_r != LAST)) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LAST);

endmodule

// File: rtl/apb_cmd_master.sv
// APB requester: converts a valid/ready command stream into SETUP/ACCESS
// transfers and returns one response per command, aborting stalled accesses.
module apb_cmd_master
    import apb_cmd_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = APB_DATA_WIDTH,
    parameter int TIMEOUT    = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    apb_state_e state_r;
    logic       timer_clear_s;
    logic       timer_en_s;
    logic       timer_expired_s;

    // Command acceptance: always in IDLE, and in RESP only as the response drains.
    always_comb begin
        cmd_ready = 1'b0;
        if (state_r == ST_IDLE) begin
            cmd_ready = 1'b1;
        end else if (state_r == ST_RESP) begin
            cmd_ready = rsp_ready;
        end else begin
            cmd_ready = 1'b0;
        end
    end

    // Wait timer control: cleared in SETUP, advanced on each stalled ACCESS cycle.
    always_comb begin
        timer_clear_s = 1'b0;
        timer_en_s    = 1'b0;
        if (state_r == ST_SETUP) begin
            timer_clear_s = 1'b1;
        end else if (state_r == ST_ACCESS) begin
            timer_en_s = ~PREADY;
        end else begin
            timer_clear_s = 1'b0;
        end
    end

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clear   (timer_clear_s),
        .enable  (timer_en_s),
        .expired (timer_expired_s)
    );

    // Transfer FSM with all bus and response outputs registered.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_r   <= ST_IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= {ADDR_WIDTH{1'b0}};
            PWDATA    <= {DATA_WIDTH{1'b0}};
            rsp_valid <= 1'b0;
            rsp_rdata <= {DATA_WIDTH{1'b0}};
            rsp_err   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        PWRITE  <= cmd_write;
                        PADDR   <= cmd_addr;
                        PWDATA  <= cmd_wdata;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        state_r <= ST_SETUP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    state_r <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= PWRITE ? {DATA_WIDTH{1'b0}} : PRDATA;
                        rsp_err   <= 1'b0;
                        state_r   <= ST_RESP;
                    end else if (timer_expired_s) begin
                        // Abort: PSEL and PENABLE fall together so the completer resets.
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= {DATA_WIDTH{1'b0}};
                        rsp_err   <= 1'b1;
                        state_r   <= ST_RESP;
                    end else begin
                        state_r <= ST_ACCESS;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (cmd_valid) begin
                            PWRITE  <= cmd_write;
                            PADDR   <= cmd_addr;
                            PWDATA  <= cmd_wdata;
                            PSEL    <= 1'b1;
                            PENABLE <= 1'b0;
                            state_r <= ST_SETUP;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    rsp_valid <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
